// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: frame-level scheduler for a 4x4 switch crossbar.
// Reserves all destination ports of one head-of-line frame per cycle,
// round-robin over inputs, with a starvation reservation for the rr head.
// Ports:
//   clk, reset       clock, async active-high reset
//   link_sync[3:0]   output j has a live peer
//   req_valid[3:0]   input i has a head-of-line frame
//   req_mask[15:0]   nibble i = destination ports of input i
//   eof[3:0]         input i finished its granted frame
//   grant[3:0]       one-cycle grant pulse per input
//   grant_mask[3:0]  ports reserved by this cycle's grant (0 = drop)
//   out_busy[3:0]    output j reserved
//   out_sel[7:0]     [2j+1:2j] = input driving output j
module crossbar_arbiter #(
   parameter int STARVE_LIMIT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  link_sync,
   input  logic [3:0]  req_valid,
   input  logic [15:0] req_mask,
   input  logic [3:0]  eof,
   output logic [3:0]  grant,
   output logic [3:0]  grant_mask,
   output logic [3:0]  out_busy,
   output logic [7:0]  out_sel
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [1:0]    rr_ptr;
   logic [CW-1:0] wait_cnt;
   logic [3:0]    holding;
   logic [3:0]    owned [4];
   logic [3:0]    eff [4];
   logic [3:0]    reserved;
   logic [3:0]    eligible;
   logic [3:0]    release_mask;
   logic          win_valid;
   logic [1:0]    win;
   logic [1:0]    rr_next;
   logic [CW-1:0] wait_next;

   // Drop dead links and the hairpin port from each request.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         eff[i] = req_mask[4*i +: 4] & link_sync & ~(4'b0001 << i);
      end
   end

   // Once the rr head has waited long enough, its ports are fenced off
   // from everyone else so they drain towards it.
   always_comb begin
      reserved = (wait_cnt >= LIMIT) ? eff[rr_ptr] : 4'b0000;
   end

   // An empty effective mask never conflicts, so drops are always eligible.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         eligible[i] = req_valid[i] && !holding[i]
                    && ((eff[i] & out_busy) == 4'b0000)
                    && ((2'(i) == rr_ptr)
                        || ((eff[i] & reserved) == 4'b0000));
      end
   end

   always_comb begin
      win_valid = 1'b0;
      win       = rr_ptr;
      for (int k = 0; k < 4; k++) begin
         if (!win_valid && eligible[rr_ptr + 2'(k)]) begin
            win_valid = 1'b1;
            win       = rr_ptr + 2'(k);
         end
      end
      rr_next = win_valid ? win + 2'd1 : rr_ptr;
   end

   always_comb begin
      release_mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (eof[i] && holding[i]) begin
            release_mask = release_mask | owned[i];
         end
      end
   end

   // A grant to the input just before the head leaves rr_ptr unchanged,
   // so the head keeps accumulating wait in that case.
   always_comb begin
      if (rr_next != rr_ptr || !req_valid[rr_ptr]) begin
         wait_next = '0;
      end else if (!holding[rr_ptr] && wait_cnt != LIMIT) begin
         wait_next = wait_cnt + CW'(1);
      end else begin
         wait_next = wait_cnt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant      <= 4'b0000;
         grant_mask <= 4'b0000;
         out_busy   <= 4'b0000;
         out_sel    <= 8'h00;
         rr_ptr     <= 2'd0;
         wait_cnt   <= '0;
         holding    <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            owned[i] <= 4'b0000;
         end
      end else begin
         grant      <= 4'b0000;
         grant_mask <= 4'b0000;
         rr_ptr     <= rr_next;
         wait_cnt   <= wait_next;
         // Eligibility used pre-release busy, so release and new
         // reservation never touch the same port.
         out_busy   <= (out_busy & ~release_mask)
                     | (win_valid ? eff[win] : 4'b0000);
         for (int i = 0; i < 4; i++) begin
            if (eof[i] && holding[i]) begin
               holding[i] <= 1'b0;
               owned[i]   <= 4'b0000;
            end
         end
         if (win_valid) begin
            grant      <= 4'b0001 << win;
            grant_mask <= eff[win];
            if (eff[win] != 4'b0000) begin
               holding[win] <= 1'b1;
               owned[win]   <= eff[win];
               for (int j = 0; j < 4; j++) begin
                  if (eff[win][j]) begin
                     out_sel[2*j +: 2] <= win;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// tb_crossbar_arbiter: directed scenarios plus randomized traffic
// checked against a frame-level reference model of the arbiter.
module tb_crossbar_arbiter;

   localparam int LIM = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  link_sync;
   logic [3:0]  req_valid;
   logic [15:0] req_mask;
   logic [3:0]  eof;
   logic [3:0]  grant;
   logic [3:0]  grant_mask;
   logic [3:0]  out_busy;
   logic [7:0]  out_sel;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [3:0] m_busy;
   int         m_sel [4];
   bit   [3:0] m_hold;
   logic [3:0] m_own [4];
   int         m_rr;
   int         m_wc;
   logic [3:0] m_gr;
   logic [3:0] m_gm;

   crossbar_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk        (clk),
      .reset      (reset),
      .link_sync  (link_sync),
      .req_valid  (req_valid),
      .req_mask   (req_mask),
      .eof        (eof),
      .grant      (grant),
      .grant_mask (grant_mask),
      .out_busy   (out_busy),
      .out_sel    (out_sel)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m_busy = 4'b0000;
      m_hold = 4'b0000;
      m_rr   = 0;
      m_wc   = 0;
      m_gr   = 4'b0000;
      m_gm   = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         m_sel[i] = 0;
         m_own[i] = 4'b0000;
      end
   endtask

   task automatic do_reset;
      reset     = 1'b1;
      req_valid = 4'b0000;
      req_mask  = 16'h0000;
      eof       = 4'b0000;
      link_sync = 4'b1111;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   // One arbitration cycle at frame level: pick the first requester in
   // rotation whose ports are free and not fenced for a starving head.
   task automatic model_step(input logic [3:0] rv,
                             input logic [15:0] rm,
                             input logic [3:0] ls,
                             input logic [3:0] e);
      logic [3:0] eff [4];
      logic [3:0] res;
      logic [3:0] busy0;
      int w;
      int c;
      int head;
      bit head_hold;
      busy0     = m_busy;
      head      = m_rr;
      head_hold = m_hold[head];
      for (int i = 0; i < 4; i++) begin
         eff[i]    = rm[4*i +: 4] & ls;
         eff[i][i] = 1'b0;
      end
      res = (m_wc >= LIM) ? eff[head] : 4'b0000;
      w = -1;
      for (int k = 0; k < 4; k++) begin
         c = (head + k) % 4;
         if (w < 0 && rv[c] && !m_hold[c]
             && (eff[c] & busy0) == 4'b0000
             && (c == head || (eff[c] & res) == 4'b0000))
            w = c;
      end
      m_gr = 4'b0000;
      m_gm = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (e[i] && m_hold[i]) begin
            m_busy   = m_busy & ~m_own[i];
            m_hold[i] = 1'b0;
            m_own[i]  = 4'b0000;
         end
      end
      if (w >= 0) begin
         m_gr[w] = 1'b1;
         m_gm    = eff[w];
         m_rr    = (w + 1) % 4;
         if (eff[w] != 4'b0000) begin
            m_busy    = m_busy | eff[w];
            m_hold[w] = 1'b1;
            m_own[w]  = eff[w];
            for (int j = 0; j < 4; j++)
               if (eff[w][j]) m_sel[j] = w;
         end
      end
      if (m_rr != head || !rv[head]) m_wc = 0;
      else if (!head_hold && m_wc < LIM) m_wc = m_wc + 1;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("FAIL reset_grant: got %b want 0000", grant);
      end
      checks++;
      if (grant_mask !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gmask: got %b want 0000", grant_mask);
      end
      checks++;
      if (out_busy !== 4'b0000) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0000", out_busy);
      end
      checks++;
      if (out_sel !== 8'h00) begin
         errors++;
         $display("FAIL reset_sel: got %h want 00", out_sel);
      end
   endtask

   task automatic test_unicast;
      do_reset();
      req_valid = 4'b0001;
      req_mask  = 16'h0004;
      tick();
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL uni_grant: got %b want 0001", grant);
      end
      checks++;
      if (grant_mask !== 4'b0100) begin
         errors++;
         $display("FAIL uni_gmask: got %b want 0100", grant_mask);
      end
      checks++;
      if (out_busy !== 4'b0100) begin
         errors++;
         $display("FAIL uni_busy: got %b want 0100", out_busy);
      end
      checks++;
      if (out_sel[5:4] !== 2'd0) begin
         errors++;
         $display("FAIL uni_sel: got %0d want 0", out_sel[5:4]);
      end
      req_valid = 4'b0000;
      tick();
      checks++;
      if (grant !== 4'b0000 || out_busy !== 4'b0100) begin
         errors++;
         $display("FAIL uni_hold: got g=%b b=%b want g=0000 b=0100",
                  grant, out_busy);
      end
      eof = 4'b0001;
      tick();
      eof = 4'b0000;
      checks++;
      if (out_busy !== 4'b0000) begin
         errors++;
         $display("FAIL uni_release: got %b want 0000", out_busy);
      end
   endtask

   // Every input asks for all ports, so any two requests overlap and
   // grants must rotate strictly 0,1,2,3,0.
   task automatic test_round_robin;
      int st [4];
      int cnt [4];
      int seq [$];
      int n;
      do_reset();
      req_mask  = 16'hFFFF;
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         st[i]  = 1;
         cnt[i] = 0;
      end
      n = 0;
      while (seq.size() < 5 && n < 200) begin
         tick();
         n++;
         for (int i = 0; i < 4; i++)
            if (grant[i]) seq.push_back(i);
         eof = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if (st[i] == 1 && grant[i]) begin
               st[i] = 2;
               cnt[i] = 3;
               req_valid[i] = 1'b0;
            end else if (st[i] == 2) begin
               cnt[i]--;
               if (cnt[i] == 0) begin
                  eof[i] = 1'b1;
                  st[i] = 3;
               end
            end else if (st[i] == 3) begin
               st[i] = 1;
               req_valid[i] = 1'b1;
            end
         end
      end
      checks++;
      if (seq.size() < 5) begin
         errors++;
         $display("FAIL rr_timeout: got %0d grants want 5", seq.size());
      end
      for (int k = 0; k < seq.size() && k < 5; k++) begin
         checks++;
         if (seq[k] != k % 4) begin
            errors++;
            $display("FAIL rr_order[%0d]: got %0d want %0d",
                     k, seq[k], k % 4);
         end
      end
   endtask

   task automatic test_starvation;
      int st [4];
      int cnt [4];
      int n;
      bit got;
      logic [3:0] gm;
      do_reset();
      req_valid = 4'b0100;
      req_mask  = 16'h0200;
      tick();
      checks++;
      if (grant !== 4'b0100) begin
         errors++;
         $display("FAIL starve_first: got %b want 0100", grant);
      end
      req_mask  = 16'h220E;
      req_valid = 4'b1001;
      st[2] = 2;
      cnt[2] = 4;
      st[3] = 1;
      cnt[3] = 0;
      n = 0;
      got = 1'b0;
      gm = 4'b0000;
      while (!got && n < 40) begin
         tick();
         n++;
         if (grant[0]) begin
            got = 1'b1;
            gm  = grant_mask;
         end
         eof = 4'b0000;
         for (int i = 2; i < 4; i++) begin
            if (st[i] == 1 && grant[i]) begin
               st[i] = 2;
               cnt[i] = 4;
               req_valid[i] = 1'b0;
            end else if (st[i] == 2) begin
               cnt[i]--;
               if (cnt[i] == 0) begin
                  eof[i] = 1'b1;
                  st[i] = 3;
               end
            end else if (st[i] == 3) begin
               st[i] = 1;
               req_valid[i] = 1'b1;
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL starve_timeout: got none in %0d want grant", n);
      end
      checks++;
      if (gm !== 4'b1110) begin
         errors++;
         $display("FAIL starve_gmask: got %b want 1110", gm);
      end
   endtask

   task automatic test_link_drop;
      do_reset();
      req_valid = 4'b0001;
      req_mask  = 16'h0008;
      tick();
      req_valid = 4'b0010;
      req_mask  = 16'h0010;
      link_sync = 4'b1110;
      tick();
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL drop_grant: got %b want 0010", grant);
      end
      checks++;
      if (grant_mask !== 4'b0000) begin
         errors++;
         $display("FAIL drop_gmask: got %b want 0000", grant_mask);
      end
      checks++;
      if (out_busy !== 4'b1000) begin
         errors++;
         $display("FAIL drop_busy: got %b want 1000", out_busy);
      end
      req_mask  = 16'h0040;
      link_sync = 4'b1111;
      tick();
      checks++;
      if (grant !== 4'b0010 || grant_mask !== 4'b0100) begin
         errors++;
         $display("FAIL drop_nohold: got g=%b m=%b want g=0010 m=0100",
                  grant, grant_mask);
      end
      checks++;
      if (out_busy !== 4'b1100 || out_sel[5:4] !== 2'd1) begin
         errors++;
         $display("FAIL drop_next: got b=%b s=%0d want b=1100 s=1",
                  out_busy, out_sel[5:4]);
      end
   endtask

   task automatic test_self_stray;
      do_reset();
      req_valid = 4'b0100;
      req_mask  = 16'h0400;
      tick();
      checks++;
      if (grant !== 4'b0100 || grant_mask !== 4'b0000) begin
         errors++;
         $display("FAIL self_drop: got g=%b m=%b want g=0100 m=0000",
                  grant, grant_mask);
      end
      req_valid = 4'b0001;
      req_mask  = 16'h0002;
      tick();
      req_valid = 4'b0000;
      checks++;
      if (out_busy !== 4'b0010 || out_sel[3:2] !== 2'd0) begin
         errors++;
         $display("FAIL self_res: got b=%b s=%0d want b=0010 s=0",
                  out_busy, out_sel[3:2]);
      end
      eof = 4'b1000;
      tick();
      eof = 4'b0000;
      checks++;
      if (out_busy !== 4'b0010 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL stray_eof: got b=%b g=%b want b=0010 g=0000",
                  out_busy, grant);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      req_valid = 4'b0100;
      req_mask  = 16'h0A00;
      tick();
      req_valid = 4'b0000;
      checks++;
      if (out_busy !== 4'b1010 || out_sel !== 8'h88) begin
         errors++;
         $display("FAIL ar_setup: got b=%b s=%h want b=1010 s=88",
                  out_busy, out_sel);
      end
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_busy !== 4'b0000 || out_sel !== 8'h00) begin
         errors++;
         $display("FAIL ar_clear: got b=%b s=%h want b=0000 s=00",
                  out_busy, out_sel);
      end
      checks++;
      if (grant !== 4'b0000 || grant_mask !== 4'b0000) begin
         errors++;
         $display("FAIL ar_grant: got g=%b m=%b want 0000",
                  grant, grant_mask);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      eof = 4'b0100;
      tick();
      eof = 4'b0000;
      checks++;
      if (out_busy !== 4'b0000) begin
         errors++;
         $display("FAIL ar_after: got %b want 0000", out_busy);
      end
   endtask

   task automatic test_random;
      int st [4];
      int cnt [4];
      do_reset();
      for (int i = 0; i < 4; i++) begin
         st[i]  = 0;
         cnt[i] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         model_step(req_valid, req_mask, link_sync, eof);
         tick();
         checks++;
         if (grant !== m_gr) begin
            errors++;
            $display("FAIL rnd_grant @%0d: got %b want %b",
                     cyc, grant, m_gr);
         end
         checks++;
         if (grant_mask !== m_gm) begin
            errors++;
            $display("FAIL rnd_gmask @%0d: got %b want %b",
                     cyc, grant_mask, m_gm);
         end
         checks++;
         if (out_busy !== m_busy) begin
            errors++;
            $display("FAIL rnd_busy @%0d: got %b want %b",
                     cyc, out_busy, m_busy);
         end
         for (int j = 0; j < 4; j++) begin
            if (m_busy[j]) begin
               checks++;
               if (out_sel[2*j +: 2] !== 2'(m_sel[j])) begin
                  errors++;
                  $display("FAIL rnd_sel%0d @%0d: got %0d want %0d",
                           j, cyc, out_sel[2*j +: 2], m_sel[j]);
               end
            end
         end
         eof = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if (st[i] == 1 && m_gr[i]) begin
               req_valid[i] = 1'b0;
               if (m_gm != 4'b0000) begin
                  st[i]  = 2;
                  cnt[i] = $urandom_range(1, 5);
               end else begin
                  st[i] = 0;
               end
            end else if (st[i] == 2) begin
               cnt[i]--;
               if (cnt[i] == 0) begin
                  eof[i] = 1'b1;
                  st[i]  = 0;
               end
            end else if (st[i] == 0) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_valid[i] = 1'b1;
                  req_mask[4*i +: 4] = 4'($urandom_range(1, 15));
                  st[i] = 1;
               end
            end
         end
         if ($urandom_range(0, 31) == 0) begin
            if ($urandom_range(0, 2) == 0)
               link_sync = 4'($urandom_range(0, 15));
            else
               link_sync = 4'b1111;
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 4'b0000;
      req_mask  = 16'h0000;
      eof       = 4'b0000;
      link_sync = 4'b1111;
      model_reset();
      test_reset();
      test_unicast();
      test_round_robin();
      test_starvation();
      test_link_drop();
      test_self_stray();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
